axi4lite_mem_responder: RTL and testbench

AXI4-Lite slave memory that answers the picorv32_axi master port. It is used as the memory and bus responder in simulation benches and in formal harnesses around the core. It accepts the AW and W channels independently and commits byte-strobed writes to an internal word RAM. It serves single reads with a registered response. Ready-deassertion, response-holding and data-stability rules are guaranteed by construction, so a master-side property check can be run against it unconstrained.

---
 rtl/axi4lite_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_axi4lite_mem_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_mem_responder.sv
// AXI4-Lite slave memory for the picorv32_axi master port.
// Independent AW/W acceptance into one-deep buffers, byte-strobed commit to a
// word RAM, single outstanding read with a registered response, and optional
// post-transaction stall windows on each side.
//
// Handshake rule for every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1. A ready only falls after a handshake on
// its own channel (or reset). A valid stays high with stable payload until it
// is sampled together with its ready.
module axi4lite_mem_responder #(
    parameter int          MEM_WORDS    = 1024,
    parameter int          STALL_CYCLES = 0,
    parameter logic [31:0] OOB_DATA     = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,

    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,

    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,

    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,

    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata,

    output logic [7:0]  oob_count
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES);

    logic [31:0] r_mem [MEM_WORDS];

    // Write-side buffers and response state
    logic        r_aw_full;
    logic [29:0] r_aw_addr;
    logic        r_w_full;
    logic [31:0] r_w_data;
    logic [3:0]  r_w_strb;
    logic        r_bvalid;
    logic [3:0]  r_wr_stall;

    // Read-side response state
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [3:0]  r_rd_stall;

    logic [7:0]  r_oob_count;

    logic        w_awready;
    logic        w_wready;
    logic        w_arready;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_ar_hs;
    logic        w_b_hs;
    logic        w_r_hs;
    logic        w_commit;
    logic        w_aw_in_range;
    logic        w_ar_in_range;
    logic [1:0]  w_oob_inc;
    logic [8:0]  w_oob_sum;
    logic        w_unused;

    // Readies depend only on buffer/stall state and reset, never on valids
    assign w_awready = !r_aw_full && (r_wr_stall == 4'd0) && !reset;
    assign w_wready  = !r_w_full  && (r_wr_stall == 4'd0) && !reset;
    assign w_arready = !r_rvalid  && (r_rd_stall == 4'd0) && !reset;

    assign w_aw_hs = mem_axi_awvalid && w_awready;
    assign w_w_hs  = mem_axi_wvalid  && w_wready;
    assign w_ar_hs = mem_axi_arvalid && w_arready;
    assign w_b_hs  = r_bvalid && mem_axi_bready;
    assign w_r_hs  = r_rvalid && mem_axi_rready;

    // A commit needs both halves of the write and a free response slot
    assign w_commit = r_aw_full && r_w_full && !r_bvalid && !reset;

    assign w_aw_in_range = ({2'b00, r_aw_addr} < 32'(MEM_WORDS));
    assign w_ar_in_range = ({2'b00, mem_axi_araddr[31:2]} < 32'(MEM_WORDS));

    // Out-of-range write commit and out-of-range read can land in one cycle
    assign w_oob_inc = {1'b0, (w_commit && !w_aw_in_range)}
                     + {1'b0, (w_ar_hs && !w_ar_in_range)};
    assign w_oob_sum = {1'b0, r_oob_count} + {7'd0, w_oob_inc};

    // Protection bits and byte offsets carry no meaning for a word memory
    assign w_unused = ^{mem_axi_awprot, mem_axi_arprot,
                        mem_axi_awaddr[1:0], mem_axi_araddr[1:0]};

    // Control state: buffers, responses, stall counters, out-of-range counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aw_full   <= 1'b0;
            r_aw_addr   <= 30'd0;
            r_w_full    <= 1'b0;
            r_w_data    <= 32'd0;
            r_w_strb    <= 4'd0;
            r_bvalid    <= 1'b0;
            r_wr_stall  <= 4'd0;
            r_rvalid    <= 1'b0;
            r_rdata     <= 32'd0;
            r_rd_stall  <= 4'd0;
            r_oob_count <= 8'd0;
        end else begin
            // AW buffer: a handshake needs it empty, a commit needs it full
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_addr <= mem_axi_awaddr[31:2];
            end else if (w_commit) begin
                r_aw_full <= 1'b0;
            end

            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_w_data <= mem_axi_wdata;
                r_w_strb <= mem_axi_wstrb;
            end else if (w_commit) begin
                r_w_full <= 1'b0;
            end

            if (w_commit) begin
                r_bvalid <= 1'b1;
            end else if (w_b_hs) begin
                r_bvalid <= 1'b0;
            end

            if (w_commit) begin
                r_wr_stall <= STALL_LOAD;
            end else if (r_wr_stall != 4'd0) begin
                r_wr_stall <= r_wr_stall - 4'd1;
            end

            // Read data is captured at the AR handshake; the RAM write of a
            // same-cycle commit is not yet visible, so the old word is returned
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_ar_in_range ? r_mem[mem_axi_araddr[IDX_W+1:2]]
                                          : OOB_DATA;
            end else if (w_r_hs) begin
                r_rvalid <= 1'b0;
            end

            if (w_r_hs) begin
                r_rd_stall <= STALL_LOAD;
            end else if (r_rd_stall != 4'd0) begin
                r_rd_stall <= r_rd_stall - 4'd1;
            end

            r_oob_count <= w_oob_sum[8] ? 8'hFF : w_oob_sum[7:0];
        end
    end

    // RAM byte-lane write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_commit && w_aw_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (r_w_strb[i]) begin
                    r_mem[r_aw_addr[IDX_W-1:0]][8*i +: 8] <= r_w_data[8*i +: 8];
                end
            end
        end
    end

    assign mem_axi_awready = w_awready;
    assign mem_axi_wready  = w_wready;
    assign mem_axi_arready = w_arready;
    assign mem_axi_bvalid  = r_bvalid;
    assign mem_axi_rvalid  = r_rvalid;
    assign mem_axi_rdata   = r_rdata;
    assign oob_count       = r_oob_count;

endmodule

// File: tb/tb_axi4lite_mem_responder.sv
// Bench for axi4lite_mem_responder: directed transactions, expected read data
// and write responses queued at issue time, checked by an independent monitor.
module tb_axi4lite_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_axi_awvalid = 1'b0;
    logic        mem_axi_awready;
    logic [31:0] mem_axi_awaddr = 32'd0;
    logic [2:0]  mem_axi_awprot = 3'd0;
    logic        mem_axi_wvalid = 1'b0;
    logic        mem_axi_wready;
    logic [31:0] mem_axi_wdata = 32'd0;
    logic [3:0]  mem_axi_wstrb = 4'd0;
    logic        mem_axi_bvalid;
    logic        mem_axi_bready = 1'b1;
    logic        mem_axi_arvalid = 1'b0;
    logic        mem_axi_arready;
    logic [31:0] mem_axi_araddr = 32'd0;
    logic [2:0]  mem_axi_arprot = 3'd0;
    logic        mem_axi_rvalid;
    logic        mem_axi_rready = 1'b1;
    logic [31:0] mem_axi_rdata;
    logic [7:0]  oob_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_b_q[$];

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, want end of test");
        $fatal(1, "watchdog expired");
    end

    axi4lite_mem_responder #(
        .MEM_WORDS   (1024),
        .STALL_CYCLES(3),
        .OOB_DATA    (32'hDEADBEEF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_axi_awvalid(mem_axi_awvalid),
        .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr (mem_axi_awaddr),
        .mem_axi_awprot (mem_axi_awprot),
        .mem_axi_wvalid (mem_axi_wvalid),
        .mem_axi_wready (mem_axi_wready),
        .mem_axi_wdata  (mem_axi_wdata),
        .mem_axi_wstrb  (mem_axi_wstrb),
        .mem_axi_bvalid (mem_axi_bvalid),
        .mem_axi_bready (mem_axi_bready),
        .mem_axi_arvalid(mem_axi_arvalid),
        .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr (mem_axi_araddr),
        .mem_axi_arprot (mem_axi_arprot),
        .mem_axi_rvalid (mem_axi_rvalid),
        .mem_axi_rready (mem_axi_rready),
        .mem_axi_rdata  (mem_axi_rdata),
        .oob_count      (oob_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got no handshake in 100 cycles, want handshake", name);
    endtask

    // Drivers: called at posedge+1, return at posedge+1 after the handshake
    task automatic do_aw(input logic [31:0] addr);
        bit hs = 0;
        mem_axi_awaddr  = addr;
        mem_axi_awvalid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_axi_awready) begin hs = 1; break; end
            @(posedge clk); #1;
        end
        if (hs) begin @(posedge clk); #1; end
        mem_axi_awvalid = 1'b0;
        if (!hs) timeout_fail("aw_handshake");
    endtask

    task automatic do_w(input logic [31:0] data, input logic [3:0] strb);
        bit hs = 0;
        mem_axi_wdata  = data;
        mem_axi_wstrb  = strb;
        mem_axi_wvalid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_axi_wready) begin hs = 1; break; end
            @(posedge clk); #1;
        end
        if (hs) begin @(posedge clk); #1; end
        mem_axi_wvalid = 1'b0;
        if (!hs) timeout_fail("w_handshake");
    endtask

    task automatic do_ar(input logic [31:0] addr, input logic [31:0] exp, input bit push);
        bit hs = 0;
        if (push) exp_q.push_back(exp);
        mem_axi_araddr  = addr;
        mem_axi_arvalid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_axi_arready) begin hs = 1; break; end
            @(posedge clk); #1;
        end
        if (hs) begin @(posedge clk); #1; end
        mem_axi_arvalid = 1'b0;
        if (!hs) timeout_fail("ar_handshake");
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        exp_b_q.push_back(addr);
        fork
            do_aw(addr);
            do_w(data, strb);
        join
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_bvalid();
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (mem_axi_bvalid) begin seen = 1; break; end
        end
        @(posedge clk); #1;
        if (!seen) timeout_fail("bvalid_wait");
    endtask

    // Monitor: pops the scoreboard whenever a response is accepted
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_axi_rvalid && mem_axi_rready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rdata_unexpected: got 0x%08h, want no response", mem_axi_rdata);
                end else begin
                    check("rdata", mem_axi_rdata, exp_q.pop_front());
                end
            end
            if (mem_axi_bvalid && mem_axi_bready) begin
                n_cmp++;
                if (exp_b_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bresp_unexpected: got bvalid, want no response");
                end else begin
                    void'(exp_b_q.pop_front());
                end
            end
        end
    end

    // Directed sequence
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", {31'd0, mem_axi_awready}, 32'd0);
        check("rst_wready",  {31'd0, mem_axi_wready},  32'd0);
        check("rst_arready", {31'd0, mem_axi_arready}, 32'd0);
        check("rst_bvalid",  {31'd0, mem_axi_bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, mem_axi_rvalid},  32'd0);
        check("rst_rdata",   mem_axi_rdata, 32'd0);
        check("rst_oob",     {24'd0, oob_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_awready", {31'd0, mem_axi_awready}, 32'd1);
        check("post_rst_wready",  {31'd0, mem_axi_wready},  32'd1);
        check("post_rst_arready", {31'd0, mem_axi_arready}, 32'd1);
        @(posedge clk); #1;

        // Same-cycle AW/W, bvalid two cycles after the handshake
        exp_b_q.push_back(32'h10);
        fork
            do_aw(32'h10);
            do_w(32'hA5A5A5A5, 4'hF);
        join
        @(negedge clk);
        check("bvalid_lat1", {31'd0, mem_axi_bvalid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bvalid_lat2", {31'd0, mem_axi_bvalid}, 32'd1);
        @(posedge clk); #1;
        do_ar(32'h10, 32'hA5A5A5A5, 1);
        @(negedge clk);
        check("rvalid_lat", {31'd0, mem_axi_rvalid}, 32'd1);
        @(posedge clk); #1;

        // Preload words used later
        do_write(32'h0,  32'h0BADF00D, 4'hF);
        do_write(32'h50, 32'h01010101, 4'hF);

        // W first, AW three cycles later, then a partial-strobe overwrite
        exp_b_q.push_back(32'h20);
        do_w(32'h11223344, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        do_aw(32'h20);
        repeat (3) @(posedge clk);
        #1;
        do_write(32'h20, 32'hFFFFFFFF, 4'b0101);
        do_ar(32'h20, 32'h11FF33FF, 1);
        repeat (2) @(posedge clk);
        #1;

        // bready held low: bvalid holds, second write buffered but not committed
        mem_axi_bready = 1'b0;
        exp_b_q.push_back(32'h30);
        fork
            do_aw(32'h30);
            do_w(32'h0000CAFE, 4'hF);
        join
        wait_bvalid();
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("bvalid_hold", {31'd0, mem_axi_bvalid}, 32'd1);
                end
                @(posedge clk); #1;
            end
            begin
                fork
                    do_aw(32'h34);
                    do_w(32'hBEEF0000, 4'hF);
                join
            end
        join
        @(negedge clk);
        check("second_aw_buffered", {31'd0, mem_axi_awready}, 32'd0);
        check("second_w_buffered",  {31'd0, mem_axi_wready},  32'd0);
        check("bvalid_still", {31'd0, mem_axi_bvalid}, 32'd1);
        @(posedge clk); #1;
        exp_b_q.push_back(32'h34);
        mem_axi_bready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("both_bresp_seen", 32'(exp_b_q.size()), 32'd0);
        do_ar(32'h30, 32'h0000CAFE, 1);
        do_ar(32'h34, 32'hBEEF0000, 1);

        // rready held low: rvalid/rdata stable, arready low, then 3-cycle stall
        repeat (6) @(posedge clk);
        #1;
        mem_axi_rready = 1'b0;
        do_ar(32'h10, 32'hA5A5A5A5, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rvalid_hold",  {31'd0, mem_axi_rvalid},  32'd1);
            check("rdata_hold",   mem_axi_rdata, 32'hA5A5A5A5);
            check("arready_hold", {31'd0, mem_axi_arready}, 32'd0);
        end
        @(posedge clk); #1;
        mem_axi_rready = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("arready_stall", {31'd0, mem_axi_arready}, (k == 4) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;

        // Read coinciding with a commit to the same word sees the old value
        repeat (6) @(posedge clk);
        #1;
        exp_b_q.push_back(32'h50);
        fork
            begin
                fork
                    do_aw(32'h50);
                    do_w(32'h02020202, 4'hF);
                join
            end
            begin
                @(posedge clk); #1;
                do_ar(32'h50, 32'h01010101, 1);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        do_ar(32'h50, 32'h02020202, 1);

        // Out of range write and read, word 0 not aliased
        do_write(32'h1000, 32'h12345678, 4'hF);
        do_ar(32'h1000, 32'hDEADBEEF, 1);
        @(negedge clk);
        check("oob_count_2", {24'd0, oob_count}, 32'd2);
        @(posedge clk); #1;
        do_ar(32'h0, 32'h0BADF00D, 1);
        for (int k = 0; k < 256; k++) begin
            do_ar(32'hFFFF0000, 32'hDEADBEEF, 1);
        end
        @(negedge clk);
        check("oob_count_sat", {24'd0, oob_count}, 32'd255);
        @(posedge clk); #1;

        // Reset with a write response and a read response both outstanding
        repeat (6) @(posedge clk);
        #1;
        mem_axi_bready = 1'b0;
        mem_axi_rready = 1'b0;
        fork
            do_aw(32'h40);
            do_w(32'h5555AAAA, 4'hF);
        join
        wait_bvalid();
        do_ar(32'h40, 32'h0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_bvalid",  {31'd0, mem_axi_bvalid},  32'd0);
        check("mid_rst_rvalid",  {31'd0, mem_axi_rvalid},  32'd0);
        check("mid_rst_awready", {31'd0, mem_axi_awready}, 32'd0);
        check("mid_rst_wready",  {31'd0, mem_axi_wready},  32'd0);
        check("mid_rst_arready", {31'd0, mem_axi_arready}, 32'd0);
        check("mid_rst_oob",     {24'd0, oob_count}, 32'd0);
        @(posedge clk); #1;
        mem_axi_bready = 1'b1;
        mem_axi_rready = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_ar(32'h10, 32'hA5A5A5A5, 1);
        do_ar(32'h20, 32'h11FF33FF, 1);
        repeat (10) @(posedge clk);
        #1;
        check("read_queue_drained",  32'(exp_q.size()), 32'd0);
        check("bresp_queue_drained", 32'(exp_b_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
